// File: rtl/ks_adder_pkg.sv
// rtl/ks_adder_pkg.sv - shared types and prefix operator for the Kogge-Stone adder
//
// Purpose : common width constants, the per-bit {p,g} pair type and the
//           Kogge-Stone prefix (dot) operator used by every network level.
// Contents: KS_WIDTH, KS_LEVELS, pg_pair_t, ks_dot()
package ks_adder_pkg;

  localparam int KS_WIDTH  = 16;
  localparam int KS_LEVELS = 4;

  // p is the MSB so a packed array of pairs lines up with the wire format
  // {p_i, g_i} at bits [2i+1:2i].
  typedef struct packed {
    logic p;
    logic g;
  } pg_pair_t;

  // (G,P) o (G',P') = (G | P&G', P&P'); hi is the more significant group.
  function automatic pg_pair_t ks_dot(input pg_pair_t hi, input pg_pair_t lo);
    pg_pair_t res;
    res.g = hi.g | (hi.p & lo.g);
    res.p = hi.p & lo.p;
    return res;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// rtl/ks_prefix_level.sv - one combinational Kogge-Stone prefix level
//
// Purpose : combines each group with the group SPAN positions below it.
//           Positions below SPAN already cover bit 0 and pass through.
// Params  : SPAN     - distance to the combined lower group (1, 2, 4, 8)
// Ports   : pg_prev  - group (G,P) pairs entering this level
//           pg_next  - group (G,P) pairs leaving this level
module ks_prefix_level
  import ks_adder_pkg::*;
#(
  parameter int SPAN = 1
) (
  input  pg_pair_t [KS_WIDTH-1:0] pg_prev,
  output pg_pair_t [KS_WIDTH-1:0] pg_next
);

  for (genvar i = 0; i < KS_WIDTH; i++) begin : g_bit
    if (i < SPAN) begin : g_pass
      assign pg_next[i] = pg_prev[i];
    end else begin : g_dot
      assign pg_next[i] = ks_dot(pg_prev[i], pg_prev[i-SPAN]);
    end
  end

endmodule

// File: rtl/ks_prefix_sum_pipe.sv
// rtl/ks_prefix_sum_pipe.sv - 2-stage pipelined Kogge-Stone prefix network and sum
//
// Purpose : consumes per-bit {p,g} pairs plus carry-in, runs the span 1/2
//           levels before S1 and the span 4/8 levels before S2, and emits
//           sum and carry-out with valid/ready handshakes on both sides.
// Option  : KS_PREFIX_OVF_EN adds out_ovf (signed overflow, c15 ^ c16).
// Ports   : clk, rst (sync, active-high)
//           in_pg[2i+1]=p_i, in_pg[2i]=g_i; in_cin; in_valid/in_ready
//           out_sum, out_cout, [out_ovf], out_valid/out_ready
module ks_prefix_sum_pipe
  import ks_adder_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] in_pg,
  input  logic               in_cin,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_cout,
`ifdef KS_PREFIX_OVF_EN
  output logic               out_ovf,
`endif
  output logic               out_valid,
  input  logic               out_ready
);

  if (WIDTH != KS_WIDTH) begin : g_width_check
    $error("ks_prefix_sum_pipe: only WIDTH=16 is supported");
  end

  // Handshake / stall control. in_ready depends on out_ready and state only,
  // never on in_valid.
  logic s1_valid;
  logic s1_en;
  logic s2_en;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  // Stage 1: carry-in fold plus span 1 and 2 levels.
  pg_pair_t [KS_WIDTH-1:0] pg_raw;
  pg_pair_t [KS_WIDTH-1:0] pg_fold;
  pg_pair_t [KS_WIDTH-1:0] lvl1;
  pg_pair_t [KS_WIDTH-1:0] lvl2;
  logic     [KS_WIDTH-1:0] p_raw;

  assign pg_raw = in_pg;

  always_comb begin
    pg_fold = pg_raw;
    // Folding cin into g0 makes every G[i:0] the true carry into bit i+1.
    pg_fold[0].g = pg_raw[0].g | (pg_raw[0].p & in_cin);
    p_raw = '0;
    for (int i = 0; i < KS_WIDTH; i++) begin
      p_raw[i] = pg_raw[i].p;
    end
  end

  ks_prefix_level #(.SPAN(1)) u_lvl1 (.pg_prev(pg_fold), .pg_next(lvl1));
  ks_prefix_level #(.SPAN(2)) u_lvl2 (.pg_prev(lvl1),    .pg_next(lvl2));

  pg_pair_t [KS_WIDTH-1:0] s1_gp;
  logic     [KS_WIDTH-1:0] s1_p;
  logic                    s1_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_gp    <= '0;
      s1_p     <= '0;
      s1_cin   <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      s1_gp    <= lvl2;
      s1_p     <= p_raw;
      s1_cin   <= in_cin;
    end
  end

  // Stage 2: span 4 and 8 levels, then carries and sum.
  pg_pair_t [KS_WIDTH-1:0] lvl4;
  pg_pair_t [KS_WIDTH-1:0] lvl8;
  logic     [KS_WIDTH:0]   carry;
  logic     [KS_WIDTH-1:0] sum_next;

  ks_prefix_level #(.SPAN(4)) u_lvl4 (.pg_prev(s1_gp), .pg_next(lvl4));
  ks_prefix_level #(.SPAN(8)) u_lvl8 (.pg_prev(lvl4),  .pg_next(lvl8));

  always_comb begin
    carry    = '0;
    carry[0] = s1_cin;
    for (int i = 0; i < KS_WIDTH; i++) begin
      carry[i+1] = lvl8[i].g;
    end
    sum_next = s1_p ^ carry[KS_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      out_sum   <= sum_next;
      out_cout  <= carry[KS_WIDTH];
    end
  end

`ifdef KS_PREFIX_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ovf <= 1'b0;
    end else if (s2_en) begin
      out_ovf <= carry[KS_WIDTH-1] ^ carry[KS_WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_ks_prefix_sum_pipe.sv
// tb/tb_ks_prefix_sum_pipe.sv - scoreboard bench for ks_prefix_sum_pipe
module tb_ks_prefix_sum_pipe;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_pg = '0;
  logic        in_cin = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef KS_PREFIX_OVF_EN
  logic        out_ovf;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  logic [15:0] cur_a = '0;
  logic [15:0] cur_b = '0;
  logic        cur_c = 1'b0;
  logic [15:0] last_sum = '0;
  logic        last_cout = 1'b0;
  logic        last_ovf = 1'b0;
  int          n_accepts = 0;
  int          n_pops = 0;
  int          n_in_stalls = 0;
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] held_sum = '0;
  logic        held_cout = 1'b0;

  ks_prefix_sum_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_pg     (in_pg),
    .in_cin    (in_cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef KS_PREFIX_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] make_pg(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] pg;
    for (int i = 0; i < 16; i++) begin
      pg[2*i+1] = a[i] ^ b[i];
      pg[2*i]   = a[i] & b[i];
    end
    return pg;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t e;
    logic [16:0] full;
    full   = {1'b0, a} + {1'b0, b} + {16'd0, c};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    return e;
  endfunction

  // Handshakes are observed on the falling edge; inputs only change at
  // posedge+1, so these values are exactly what the next rising edge sees.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(cur_a, cur_b, cur_c));
        n_accepts++;
      end
      if (in_valid && !in_ready) n_in_stalls++;
      if (prev_stall) begin
        check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
        check_eq("stall_sum", {16'd0, out_sum}, {16'd0, held_sum});
        check_eq("stall_cout", {31'd0, out_cout}, {31'd0, held_cout});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("sum", {16'd0, out_sum}, {16'd0, e.sum});
          check_eq("cout", {31'd0, out_cout}, {31'd0, e.cout});
`ifdef KS_PREFIX_OVF_EN
          check_eq("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
          last_ovf = out_ovf;
`endif
        end
        last_sum  = out_sum;
        last_cout = out_cout;
        n_pops++;
      end
      prev_stall = out_valid && !out_ready;
      held_sum   = out_sum;
      held_cout  = out_cout;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    cur_a = a;
    cur_b = b;
    cur_c = c;
    in_pg = make_pg(a, b);
    in_cin = c;
    in_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) check_eq("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      idle(1);
      n++;
    end
    check_eq("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] esum, input logic ecout);
    send_beat(a, b, c);
    drain();
    idle(1);
    check_eq({tag, "_sum"}, {16'd0, last_sum}, {16'd0, esum});
    check_eq({tag, "_cout"}, {31'd0, last_cout}, {31'd0, ecout});
  endtask

  initial begin
    int acc0;
    int pops0;
    int st0;

    // Reset state.
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_sum", {16'd0, out_sum}, 32'd0);
    check_eq("rst_out_cout", {31'd0, out_cout}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single beat latency.
    out_ready = 1'b1;
    send_beat(16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    check_eq("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    idle(1);
    check_eq("lat_sum", {16'd0, last_sum}, 32'h0100);
    check_eq("lat_cout", {31'd0, last_cout}, 32'd0);

    // Wrap-around and carry-in.
    directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    directed("cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    directed("ovfcase", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
`ifdef KS_PREFIX_OVF_EN
    check_eq("ovf_flag", {31'd0, last_ovf}, 32'd1);
`endif

    // Backpressure: 4 back-to-back beats with out_ready low for 5 cycles.
    out_ready = 1'b0;
    acc0 = n_accepts;
    fork
      begin
        send_beat(16'h1234, 16'h4321, 1'b0);
        send_beat(16'h8000, 16'h8000, 1'b0);
        send_beat(16'h0F0F, 16'hF0F1, 1'b0);
        send_beat(16'hAAAA, 16'h5555, 1'b0);
      end
      begin
        idle(5);
        @(negedge clk);
        check_eq("bp_accepts", n_accepts - acc0, 32'd2);
        check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    idle(1);
    check_eq("bp_last_sum", {16'd0, last_sum}, 32'hFFFF);
    check_eq("bp_last_cout", {31'd0, last_cout}, 32'd0);

    // Full throughput.
    pops0 = n_pops;
    st0 = n_in_stalls;
    for (int i = 0; i < 1000; i++) begin
      send_beat(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    idle(2);
    check_eq("thru_pops", n_pops - pops0, 32'd1000);
    check_eq("thru_in_stalls", n_in_stalls - st0, 32'd0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send_beat(16'h1111, 16'h2222, 1'b0);
    send_beat(16'h3333, 16'h4444, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_out_sum", {16'd0, out_sum}, 32'd0);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(10);

    // Random valid/ready toggling.
    pops0 = n_pops;
    rand_ready = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      while ($urandom_range(0, 1) == 0) idle(1);
      send_beat(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(5);
    check_eq("rand_pops", n_pops - pops0, 32'd5000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ks_prefix_sum_pipe.md
Name: ks_prefix_sum_pipe

Overview:
- Consumer end of the 16-bit propagate/generate interface of the Kogge-Stone adder.
- Accepts the 16 per-bit {p,g} pairs plus carry-in and runs the 4-level Kogge-Stone prefix network (spans 1, 2, 4, 8).
- Forms sum and carry-out in a 2-stage registered pipeline with a valid/ready handshake on both sides.
- Sits between the pg generation stage and the adder result register.

Parameters:
- WIDTH, 16, operand width; fixed at 16, so prefix depth is 4. Other values are unsupported and rejected by elaboration assertion.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_pg  input  32  pair i on [2i+1:2i]; bit 2i+1 = p_i (A^B), bit 2i = g_i (A&B)
- in_cin  input  1  carry-in
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept a beat this cycle
- out_sum  output  16  sum
- out_cout  output  1  carry out of bit 15
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result

Behaviour:
- Handshake: a transfer occurs on any cycle where valid && ready is high at a rising edge.
  - Upstream must hold in_pg/in_cin stable while in_valid && !in_ready.
  - Downstream sees out_sum/out_cout held stable while out_valid && !out_ready.
- Carry-in folding: g0' = g0 | (p0 & cin) before the network; c0 = cin.
- Prefix operator: (G,P)o(G',P') = (G | P&G', P&P').
- Stage 1, register S1: levels span 1 and 2 are computed combinationally from in_pg; S1 captures intermediate (G,P)[15:0], the original p[15:0], cin, and s1_valid.
- Stage 2, register S2: levels span 4 and 8 are computed from S1.
  - c_{i+1} = G[i:0]; sum_i = p_i ^ c_i; cout = G[15:0].
  - S2 holds out_sum, out_cout, and out_valid.
- Latency: 2 cycles from accepted input to out_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Stall logic, no combinational path from in_valid to in_ready:
  - s2_en = !out_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en
  - S2 loads from S1 when s2_en. out_valid <= s1_valid in that case.
  - S1 loads from the input when s1_en. s1_valid <= in_valid in that case.
- Combinational paths: out_ready feeds in_ready through 2 gate levels. This is accepted; no skid buffer.
- Full pipeline with out_ready=0: both stages hold, in_ready=0, and no data is lost or duplicated.
- Simultaneous out handshake and in handshake on a full pipeline: all stages advance in the same cycle.
- Reset, including mid-operation: s1_valid=0, out_valid=0, out_sum=0, out_cout=0, S1 data=0, and in-flight beats are discarded.
  - in_ready is 1 in the first cycle after reset deasserts.
- Illegal pair p_i=g_i=1 (never produced by the pg stage): processed arithmetically as-is, no flag. The bench does not drive it.
- Wrap-around: 0xFFFF+0x0001 gives sum 0x0000, cout=1. No saturation.

Optional Feature:
- Macro KS_PREFIX_OVF_EN.
- Defined:
  - Adds port out_ovf (output, 1), signed overflow = c15 ^ c16, registered in S2 alongside the sum.
  - Reset value 0; follows the same stall rules as the sum.
- Undefined: the port and logic are absent; the port list is otherwise identical.

Decomposition:
- Package ks_adder_pkg:
  - localparam KS_WIDTH=16, KS_LEVELS=4
  - typedef pg_pair_t as a 2-bit packed struct {p,g}
  - function ks_dot implementing the prefix operator
- One sub-module is natural: ks_prefix_level (one span-parameterized combinational level, SPAN parameter), instantiated 4 times (2 per stage).

Test Plan:
- Single beat A=0x00FF, B=0x0001, cin=0, pg from the model, out_ready=1: out_valid exactly 2 cycles after accept, out_sum=0x0100, out_cout=0.
- A=0xFFFF, B=0x0001, cin=0: sum=0x0000, cout=1. Separately A=0xFFFF, B=0x0000, cin=1: sum=0x0000, cout=1. With KS_PREFIX_OVF_EN, A=0x7FFF, B=0x0001: ovf=1.
- Backpressure: stream 4 beats back-to-back (0x1234+0x4321, 0x8000+0x8000, 0x0F0F+0xF0F1, 0xAAAA+0x5555) with out_ready=0 for 5 cycles. Required:
  - in_ready falls after 2 accepts.
  - Results appear in order once out_ready=1: 0x5555/0, 0x0000/1, 0x0000/1, 0xFFFF/0.
  - Output held stable during the stall.
- Full throughput: 1000 random beats with in_valid and out_ready held at 1: one result per cycle, all matching the A+B+cin reference, no bubbles.
- Reset mid-operation: assert rst for 1 cycle while 2 beats are in flight. Next cycle: out_valid=0, out_sum=0, in_ready=1, and no stale result ever emerges.
- Random in_valid/out_ready toggling (50%), 5000 beats: scoreboard confirms no loss, duplication, or reordering, and the stability rules hold.
